// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access path: access modes, FSM
// encoding and the alignment rule used to reject requests before they reach memory.
package mem_pkg;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sgn;
  } req_ctl_t;

  // True when the access must not touch memory: reserved size or an address
  // that is not a multiple of the access size.
  function automatic logic access_error(input logic [1:0] size, input logic [1:0] addr_lo);
    logic err;
    err = 1'b0;
    case (size)
      MODE_BYTE: err = 1'b0;
      MODE_HALF: err = addr_lo[0];
      MODE_WORD: err = (addr_lo != 2'b00);
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Sign/zero extension of right-justified load data; shared with the cache refill path.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] i_dout,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_dout;
    case (i_size)
      MODE_BYTE: o_data = {{24{i_signed & i_dout[7]}}, i_dout[7:0]};
      MODE_HALF: o_data = {{16{i_signed & i_dout[15]}}, i_dout[15:0]};
      default:   o_data = i_dout;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side initiator for the data memory: one request at a time, one-cycle
// memory strobe, registered extended response held until consumed.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic [1:0]            mem_mode,
  output logic                  mem_str,
  output logic                  mem_sel,
  output logic                  mem_ld,
  input  logic [31:0]           mem_dout
);

  state_t                r_state, w_state_nxt;
  req_ctl_t              r_ctl;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_req_err;
  logic                  w_done;
  logic [31:0]           w_ext;

  assign w_accept  = req_valid && (r_state == ST_IDLE);
  assign w_req_err = access_error(req_size, req_addr[1:0]);
  assign w_done    = (r_state == ST_RESP) && resp_ready;

  load_extend u_ext (
    .i_dout   (mem_dout),
    .i_size   (r_ctl.size),
    .i_signed (r_ctl.sgn),
    .o_data   (w_ext)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_sel     = 1'b0;
    mem_str     = 1'b0;
    mem_ld      = 1'b0;
    mem_mode    = '0;
    mem_addr    = '0;
    mem_din     = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = w_req_err ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_sel     = 1'b1;
        mem_str     = r_ctl.we;
        mem_ld      = !r_ctl.we;
        mem_mode    = r_ctl.size;
        mem_addr    = r_addr;
        mem_din     = r_wdata;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Response data is cleared on accept so stores and errors return 0; a load
  // overwrites it with the extended memory word at the end of ISSUE.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_ctl   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_ctl   <= '{we: req_we, size: req_size, sgn: req_signed};
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_rdata <= '0;
      r_err   <= w_req_err;
    end else if (r_state == ST_ISSUE) begin
      r_rdata <= r_ctl.we ? 32'h0 : w_ext;
    end else if (w_done) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a transaction-level model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_ready = 1'b0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_din, mem_dout;
  logic [11:0] mem_addr;
  logic [1:0]  mem_mode;
  logic        mem_str, mem_sel, mem_ld;

  int checks = 0, failures = 0;
  bit rand_rr = 0;

  mem_access_unit #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_mode(mem_mode),
    .mem_str(mem_str), .mem_sel(mem_sel), .mem_ld(mem_ld), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Physical memory driven only by the DUT's pins; little-endian, zero-filled above size.
  logic [7:0] phys_mem [0:4095];
  logic [7:0] ref_mem  [0:4095];

  always_comb begin
    mem_dout = '0;
    for (int i = 0; i < 4; i++)
      if (i < nbytes(mem_mode)) mem_dout[8*i +: 8] = phys_mem[12'(mem_addr + 12'(i))];
  end

  initial forever begin
    @(posedge clk);
    if (mem_sel && mem_str)
      for (int i = 0; i < nbytes(mem_mode); i++)
        phys_mem[12'(mem_addr + 12'(i))] <= mem_din[8*i +: 8];
  end

  // Transaction model: one outstanding request, timed by cycles since acceptance.
  bit          m_pend, m_err, m_we, m_sgn;
  int          m_t;
  logic [1:0]  m_size;
  logic [11:0] m_addr;
  logic [31:0] m_wdata, m_rdata;

  function automatic bit m_rv();
    return m_pend && (m_err || m_t >= 1);
  endfunction

  function automatic logic [31:0] ref_load(input logic [11:0] a, input logic [1:0] sz, input bit sg);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (32'(ref_mem[12'(a + 12'(i))]) << (8 * i));
    if (sg && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  initial forever begin
    @(posedge clk or posedge clr);
    if (clr) m_pend = 0;
    else if (m_pend) begin
      if (m_rv() && resp_ready) m_pend = 0;
      else begin
        if (m_t == 0 && !m_err) begin
          if (m_we) for (int i = 0; i < nbytes(m_size); i++)
                      ref_mem[12'(m_addr + 12'(i))] = m_wdata[8*i +: 8];
          else m_rdata = ref_load(m_addr, m_size, m_sgn);
        end
        m_t++;
      end
    end else if (req_valid) begin
      m_pend  = 1;
      m_t     = 0;
      m_we    = req_we;
      m_size  = req_size;
      m_sgn   = req_signed;
      m_addr  = req_addr;
      m_wdata = req_wdata;
      m_rdata = 0;
      m_err   = (req_size == 2'b11) || (req_addr % nbytes(req_size) != 0);
    end
  end

  // Every-cycle compare of all outputs against the model.
  initial forever begin
    bit iss;
    @(negedge clk);
    iss = m_pend && !m_err && m_t == 0;
    chk("req_ready", 32'(req_ready), 32'(!m_pend));
    chk("resp_valid", 32'(resp_valid), 32'(m_rv()));
    if (m_rv()) begin
      chk("resp_rdata", resp_rdata, m_rdata);
      chk("resp_err", 32'(resp_err), 32'(m_err));
    end
    chk("mem_sel", 32'(mem_sel), 32'(iss));
    chk("mem_str", 32'(mem_str), 32'(iss && m_we));
    chk("mem_ld", 32'(mem_ld), 32'(iss && !m_we));
    chk("mem_mode", 32'(mem_mode), iss ? 32'(m_size) : 32'h0);
    chk("mem_addr", 32'(mem_addr), iss ? 32'(m_addr) : 32'h0);
    chk("mem_din", mem_din, iss ? m_wdata : 32'h0);
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (rand_rr) resp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send_req(input bit we, input logic [1:0] sz, input bit sg,
                          input logic [11:0] a, input logic [31:0] wd);
    bit rdy;
    int n;
    n = 0;
    @(negedge clk); #1;
    req_valid = 1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    forever begin
      rdy = req_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 200) begin chk("req_accept_timeout", 32'd0, 32'd1); break; end
      @(negedge clk); #1;
    end
    #1 req_valid = 0;
  endtask

  // Directed access with literal expectation and a stall of `hold` cycles on the response.
  task automatic txn(input string nm, input bit we, input logic [1:0] sz, input bit sg,
                     input logic [11:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_d, input bit exp_e, input int hold);
    bit seen;
    seen = 0;
    send_req(we, sz, sg, a, wd);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = resp_valid;
    end
    chk({nm, "_resp_seen"}, 32'(seen), 32'd1);
    chk({nm, "_rdata"}, resp_rdata, exp_d);
    chk({nm, "_err"}, 32'(resp_err), 32'(exp_e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(resp_valid), 32'd1);
      chk({nm, "_hold_rdata"}, resp_rdata, exp_d);
      chk({nm, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    #1 resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      phys_mem[i] = 8'($urandom);
      ref_mem[i]  = phys_mem[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_sel", 32'(mem_sel), 32'd0);
    #1 clr = 0;

    txn("st_w",   1, 2'b10, 0, 12'h010, 32'hDEADBEEF, 32'h0, 0, 0);
    txn("ld_w",   0, 2'b10, 0, 12'h010, 32'h0, 32'hDEADBEEF, 0, 0);
    txn("st_b",   1, 2'b00, 0, 12'h013, 32'hAAAAAA80, 32'h0, 0, 0);
    txn("ld_bs",  0, 2'b00, 1, 12'h013, 32'h0, 32'hFFFFFF80, 0, 0);
    txn("ld_bu",  0, 2'b00, 0, 12'h013, 32'h0, 32'h00000080, 0, 0);
    txn("ld_w2",  0, 2'b10, 0, 12'h010, 32'h0, 32'h80ADBEEF, 0, 0);
    txn("st_h",   1, 2'b01, 0, 12'h022, 32'h55558001, 32'h0, 0, 0);
    txn("ld_hs",  0, 2'b01, 1, 12'h022, 32'h0, 32'hFFFF8001, 0, 0);
    txn("ld_hu",  0, 2'b01, 0, 12'h022, 32'h0, 32'h00008001, 0, 0);
    txn("mis_w",  0, 2'b10, 0, 12'h011, 32'h0, 32'h0, 1, 0);
    txn("mis_h",  1, 2'b01, 0, 12'h021, 32'h1234, 32'h0, 1, 0);
    txn("rsvd",   0, 2'b11, 1, 12'h000, 32'h0, 32'h0, 1, 0);
    txn("hold",   0, 2'b10, 0, 12'h010, 32'h0, 32'h80ADBEEF, 0, 5);
    txn("st_old", 1, 2'b10, 0, 12'h040, 32'hCAFEF00D, 32'h0, 0, 0);

    // Reset arriving mid-ISSUE of a store must abort it.
    send_req(1, 2'b10, 0, 12'h040, 32'h12345678);
    @(negedge clk);
    #2 clr = 1;
    #1;
    chk("clr_mem_sel", 32'(mem_sel), 32'd0);
    chk("clr_mem_str", 32'(mem_str), 32'd0);
    chk("clr_mem_addr", 32'(mem_addr), 32'd0);
    chk("clr_req_ready", 32'(req_ready), 32'd1);
    chk("clr_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk); #1 clr = 0;
    txn("ld_old", 0, 2'b10, 0, 12'h040, 32'h0, 32'hCAFEF00D, 0, 0);

    rand_rr = 1;
    for (int k = 0; k < 400; k++) begin
      logic [11:0] a;
      logic [1:0]  sz;
      a  = ($urandom_range(0, 7) == 0) ? 12'(12'hFC0 + $urandom_range(0, 63)) : 12'($urandom_range(0, 63));
      sz = ($urandom_range(0, 9) < 9) ? 2'($urandom_range(0, 2)) : 2'b11;
      send_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 100 && m_pend; i++) @(negedge clk);
    chk("drain", 32'(m_pend), 32'd0);
    rand_rr = 0;
    @(negedge clk); #1 resp_ready = 0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
